// File: rtl/xbar_master_port_if.sv
// Crossbar master-port handshake bundle: request/ack with command, address and write data,
// plus the single-cycle read response path.
interface xbar_master_port_if;
  logic        req;
  logic        ack;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp;
  logic [31:0] rdata;

  modport master (output req, cmd, addr, wdata, input ack, resp, rdata);
  modport slave  (input req, cmd, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/xbar_master_port.sv
// Request buffer in front of one crossbar master port: a small FIFO of read/write transactions
// replayed onto the req/ack handshake, with a single outstanding read and a response timeout.
module xbar_master_port #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_cmd,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_wdata,
  xbar_master_port_if.master       m,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic                     rd_err,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ       = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [TW-1:0] timer;
  logic          fifo_cmd   [DEPTH];
  logic [31:0]   fifo_addr  [DEPTH];
  logic [31:0]   fifo_wdata [DEPTH];

  logic          push;
  logic          pop;
  logic          timed_out;
  logic          resp_done;
  logic [AW:0]   level_next;

  // No bypass: a full FIFO refuses input even while the head is being popped.
  assign in_ready   = (level != (AW+1)'(DEPTH)) && !reset;
  assign push       = in_valid && in_ready;
  assign pop        = (state == REQ) && m.ack;
  assign level_next = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  // A response arriving on the timeout cycle takes priority over the error.
  assign timed_out  = (TIMEOUT != 0) && (state == WAIT_RESP) && !m.resp &&
                      (timer == TW'(TIMEOUT - 1));
  assign resp_done  = (state == WAIT_RESP) && (m.resp || timed_out);

  assign m.req   = (state == REQ);
  assign m.cmd   = (state == REQ) ? fifo_cmd[rd_ptr]   : 1'b0;
  assign m.addr  = (state == REQ) ? fifo_addr[rd_ptr]  : 32'd0;
  assign m.wdata = (state == REQ) ? fifo_wdata[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr]   <= in_cmd;
      fifo_addr[wr_ptr]  <= in_addr;
      fifo_wdata[wr_ptr] <= in_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= IDLE;
      timer    <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_next;
      rd_valid <= resp_done;
      rd_err   <= resp_done && !m.resp;
      if (resp_done) rd_data <= m.resp ? m.rdata : 32'd0;

      case (state)
        IDLE: begin
          if (level != '0) state <= REQ;
        end
        REQ: begin
          if (pop) begin
            if (!fifo_cmd[rd_ptr]) begin
              state <= WAIT_RESP;
              timer <= '0;
            end else if (level_next == '0) begin
              state <= IDLE;
            end
          end
        end
        WAIT_RESP: begin
          if (timer != '1) timer <= timer + 1'b1;
          if (resp_done) state <= (level_next != '0) ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xbar_master_port.sv
// Bench for xbar_master_port: directed scenarios plus random traffic scored against a
// transaction-level model (expected FIFO queue and read-response timing).
module tb_xbar_master_port;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_cmd;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [2:0]  level;

  xbar_master_port_if bus ();

  xbar_master_port #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .in_addr  (in_addr),
    .in_wdata (in_wdata),
    .m        (bus),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .level    (level)
  );

  always #5 clk = ~clk;

  txn_t        q[$];
  int          waiting;
  int          wcnt;
  bit          exp_rv;
  bit          exp_err;
  logic [31:0] exp_rd;
  int          total;
  int          bad;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: evaluate the model from the inputs seen before the edge, then check after it.
  task automatic tick();
    bit   push;
    bit   ack;
    txn_t h;
    txn_t t;
    @(negedge clk);
    exp_rv  = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      q.delete();
      waiting = 0;
    end else begin
      push = in_valid && (q.size() < DEPTH);
      ack  = bus.req && bus.ack;
      if (bus.req) check_val("req_during_wait", waiting, 0);
      if (!bus.req) begin
        check_val("idle_addr", bus.addr, 32'd0);
        check_val("idle_cmd", {31'd0, bus.cmd}, 32'd0);
      end
      if (waiting != 0) begin
        if (bus.resp) begin
          exp_rv  = 1'b1;
          exp_rd  = bus.rdata;
          waiting = 0;
        end else begin
          wcnt++;
          if (wcnt == TIMEOUT) begin
            exp_rv  = 1'b1;
            exp_err = 1'b1;
            exp_rd  = 32'd0;
            waiting = 0;
          end
        end
      end
      if (ack) begin
        if (q.size() == 0) begin
          check_val("ack_with_empty_model", 32'd1, 32'd0);
        end else begin
          h = q.pop_front();
          check_val("head_cmd", {31'd0, bus.cmd}, {31'd0, h.cmd});
          check_val("head_addr", bus.addr, h.addr);
          if (h.cmd) check_val("head_wdata", bus.wdata, h.wdata);
          if (!h.cmd) begin
            waiting = 1;
            wcnt    = 0;
          end
        end
      end
      if (push) begin
        t.cmd   = in_cmd;
        t.addr  = in_addr;
        t.wdata = in_wdata;
        q.push_back(t);
      end
    end
    @(posedge clk);
    #1;
    check_val("level", {29'd0, level}, q.size());
    check_val("in_ready", {31'd0, in_ready}, {31'd0, (!reset && q.size() < DEPTH)});
    check_val("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
    check_val("rd_err", {31'd0, rd_err}, {31'd0, exp_err});
    if (exp_rv) check_val("rd_data", rd_data, exp_rd);
  endtask

  task automatic push_txn(input logic cmd, input logic [31:0] addr, input logic [31:0] wdata);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_addr  = addr;
    in_wdata = wdata;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    waiting   = 0;
    wcnt      = 0;
    exp_rd    = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_cmd    = 1'b0;
    in_addr   = '0;
    in_wdata  = '0;
    bus.ack   = 1'b0;
    bus.resp  = 1'b0;
    bus.rdata = '0;
    tick();
    tick();
    check_val("rst_req", {31'd0, bus.req}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Write then idle
    push_txn(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
    check_val("t1_req_e0", {31'd0, bus.req}, 32'd0);
    tick();
    check_val("t1_req_e1", {31'd0, bus.req}, 32'd1);
    check_val("t1_addr", bus.addr, 32'h4000_0010);
    check_val("t1_wdata", bus.wdata, 32'hDEAD_BEEF);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_val("t1_req_after_ack", {31'd0, bus.req}, 32'd0);
    repeat (3) tick();

    // Read
    push_txn(1'b0, 32'h8000_0004, 32'd0);
    tick();
    check_val("t2_req", {31'd0, bus.req}, 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    tick();
    bus.resp  = 1'b1;
    bus.rdata = 32'h1234_5678;
    tick();
    bus.resp  = 1'b0;
    bus.rdata = '0;
    check_val("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_val("t2_rd_data", rd_data, 32'h1234_5678);
    check_val("t2_rd_err", {31'd0, rd_err}, 32'd0);
    tick();
    check_val("t2_rd_valid_pulse", {31'd0, rd_valid}, 32'd0);

    // Full FIFO, then drain back-to-back
    for (int i = 0; i < 5; i++) push_txn(1'b1, 32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    check_val("t3_level_full", {29'd0, level}, 32'd4);
    check_val("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
    bus.ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("t3_no_bubble", {31'd0, bus.req}, 32'd1);
      check_val("t3_order", bus.addr, 32'h0000_1000 + 32'(i * 4));
      tick();
    end
    bus.ack = 1'b0;
    check_val("t3_drained_req", {31'd0, bus.req}, 32'd0);
    tick();

    // Timeout with a write queued behind the read
    push_txn(1'b0, 32'hC000_0020, 32'd0);
    push_txn(1'b1, 32'h4000_0044, 32'h5555_AAAA);
    check_val("t4_req_read", {31'd0, bus.req}, 32'd1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      check_val("t4_rd_valid_timing", {31'd0, rd_valid}, {31'd0, (k == TIMEOUT)});
    end
    check_val("t4_rd_err", {31'd0, rd_err}, 32'd1);
    check_val("t4_rd_data", rd_data, 32'd0);
    check_val("t4_next_req", {31'd0, bus.req}, 32'd1);
    check_val("t4_next_addr", bus.addr, 32'h4000_0044);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();

    // Reset while waiting for a read response
    push_txn(1'b0, 32'h0000_0100, 32'd0);
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    bus.resp  = 1'b1;
    bus.rdata = 32'hFEED_F00D;
    tick();
    bus.resp = 1'b0;
    check_val("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("t5_level", {29'd0, level}, 32'd0);
    check_val("t5_req", {31'd0, bus.req}, 32'd0);
    check_val("t5_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_cmd    = ($urandom_range(0, 1) == 1);
      in_addr   = $urandom;
      in_wdata  = $urandom;
      bus.ack   = ($urandom_range(0, 2) != 0);
      bus.resp  = (waiting != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      bus.rdata = $urandom;
      tick();
    end
    in_valid = 1'b0;
    bus.ack  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      bus.resp  = (waiting != 0) && ($urandom_range(0, 1) == 0);
      bus.rdata = $urandom;
      tick();
    end
    bus.ack  = 1'b0;
    bus.resp = 1'b0;
    check_val("final_level", {29'd0, level}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
